// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads a W x H image from ROM, edits a 2x2 window, streams it to RAM.
// Build option: define LCD_CTRL_AVG_ROUND_EN for round-half-up AVG (default truncates).
module lcd_ctrl_param #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_MID = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_MID = YW'(IMG_H / 2);

    localparam logic [3:0] C_WRITE = 4'd0,  C_UP   = 4'd1,  C_DOWN = 4'd2,  C_LEFT = 4'd3;
    localparam logic [3:0] C_RIGHT = 4'd4,  C_MAX  = 4'd5,  C_MIN  = 4'd6,  C_AVG  = 4'd7;
    localparam logic [3:0] C_CCW   = 4'd8,  C_CW   = 4'd9,  C_MIRX = 4'd10, C_MIRY = 4'd11;
    localparam logic [3:0] C_PRST  = 4'd12;

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WB, S_WRITE, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] irom_a_q, ld_wa_q, wr_a_q;
    logic          ld_vld_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [3:0]    cmd_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] img_q [N];

    // Window addressing: power-of-two width makes row*IMG_W+col a plain concatenation.
    logic [XW-1:0] xm;
    logic [YW-1:0] ym;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] p0, p1, p2, p3;

    assign xm = x_q - XW'(1);
    assign ym = y_q - YW'(1);
    assign a0 = {ym, xm};
    assign a1 = {ym, x_q};
    assign a2 = {y_q, xm};
    assign a3 = {y_q, x_q};
    assign p0 = img_q[a0];
    assign p1 = img_q[a1];
    assign p2 = img_q[a2];
    assign p3 = img_q[a3];

    logic [DW-1:0] mx01, mx23, mx, mn01, mn23, mn, avg, red;
    logic [DW+1:0] sum;

    assign mx01 = (p0 > p1) ? p0 : p1;
    assign mx23 = (p2 > p3) ? p2 : p3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (p0 < p1) ? p0 : p1;
    assign mn23 = (p2 < p3) ? p2 : p3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;
    assign sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
`ifdef LCD_CTRL_AVG_ROUND_EN
    logic [DW+1:0] sum_r;
    assign sum_r = sum + (DW+2)'(2);
    assign avg   = sum_r[DW+1:2];
`else
    assign avg   = sum[DW+1:2];
`endif
    assign red = (cmd_q == C_MAX) ? mx : (cmd_q == C_MIN) ? mn : avg;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    // WRITE bypasses EXEC so the first pixel is on the bus the cycle after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (ld_vld_q && ld_wa_q == LAST) state_d = S_IDLE;
            S_IDLE:  if (cmd_valid) state_d = (cmd == C_WRITE) ? S_WRITE : S_EXEC;
            S_EXEC:  state_d = (cmd_q == C_MAX || cmd_q == C_MIN || cmd_q == C_AVG) ? S_WB : S_IDLE;
            S_WB:    state_d = S_IDLE;
            S_WRITE: if (wr_a_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        IROM_rd    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        IRAM_valid = 1'b0;
        case (state_q)
            S_LOAD:  IROM_rd    = 1'b1;
            S_IDLE:  busy       = 1'b0;
            S_WRITE: IRAM_valid = 1'b1;
            S_DONE:  done       = 1'b1;
            default: ;
        endcase
    end

    assign IROM_A = irom_a_q;
    assign IRAM_A = wr_a_q;
    assign IRAM_D = IRAM_valid ? img_q[wr_a_q] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irom_a_q <= '0;
            ld_vld_q <= 1'b0;
            ld_wa_q  <= '0;
            x_q      <= X_MID;
            y_q      <= Y_MID;
            cmd_q    <= '0;
            res_q    <= '0;
            wr_a_q   <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // ROM data lags its address by one cycle; ld_wa_q tracks the address in flight.
                    if (irom_a_q != LAST) irom_a_q <= irom_a_q + AW'(1);
                    ld_vld_q <= 1'b1;
                    ld_wa_q  <= irom_a_q;
                end
                S_IDLE: if (cmd_valid) cmd_q <= cmd;
                S_EXEC: begin
                    case (cmd_q)
                        C_UP:    if (y_q != YW'(1)) y_q <= y_q - YW'(1);
                        C_DOWN:  if (y_q != Y_MAX)  y_q <= y_q + YW'(1);
                        C_LEFT:  if (x_q != XW'(1)) x_q <= x_q - XW'(1);
                        C_RIGHT: if (x_q != X_MAX)  x_q <= x_q + XW'(1);
                        C_PRST: begin
                            x_q <= X_MID;
                            y_q <= Y_MID;
                        end
                        C_MAX, C_MIN, C_AVG: res_q <= red;
                        default: ;
                    endcase
                end
                S_WRITE: wr_a_q <= wr_a_q + AW'(1);
                default: ;
            endcase
        end
    end

    // Image buffer is not reset; writes are simply suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (state_q)
                S_LOAD: if (ld_vld_q) img_q[ld_wa_q] <= IROM_Q;
                S_EXEC: begin
                    case (cmd_q)
                        C_CCW: begin
                            img_q[a0] <= p1;
                            img_q[a1] <= p3;
                            img_q[a3] <= p2;
                            img_q[a2] <= p0;
                        end
                        C_CW: begin
                            img_q[a0] <= p2;
                            img_q[a1] <= p0;
                            img_q[a3] <= p1;
                            img_q[a2] <= p3;
                        end
                        C_MIRX: begin
                            img_q[a0] <= p2;
                            img_q[a2] <= p0;
                            img_q[a1] <= p3;
                            img_q[a3] <= p1;
                        end
                        C_MIRY: begin
                            img_q[a0] <= p1;
                            img_q[a1] <= p0;
                            img_q[a2] <= p3;
                            img_q[a3] <= p2;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    img_q[a0] <= res_q;
                    img_q[a1] <= res_q;
                    img_q[a2] <= res_q;
                    img_q[a3] <= res_q;
                end
                default: ;
            endcase
        end
    end
endmodule
